// File: rtl/ddf_2f_tag_split.sv
// +----------------------------------------------------------------------------+
// | ddf_2f_tag_split                                                           |
// | Strips the tag bit from FWFT tokens and routes each payload to one of two  |
// | output FIFOs through a one-entry holding slot per flow.                    |
// | Optional: DDF_SPLIT_CNT_EN adds per-flow write counters.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module ddf_2f_tag_split #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_empty,
  output logic                 in_read,
  input  logic                 out0_full,
  output logic                 out0_wr,
  output logic [WIDTH-2:0]     out0_data,
  input  logic                 out1_full,
  output logic                 out1_wr,
  output logic [WIDTH-2:0]     out1_data
`ifdef DDF_SPLIT_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] out0_cnt,
  output logic [CNT_WIDTH-1:0] out1_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } slot_state_t;

  slot_state_t        r_st0, r_st1;
  logic [WIDTH-2:0]   r_hold0, r_hold1;

  logic               w_tag;
  logic               w_free0, w_free1;
  logic               w_load0, w_load1;

  // Drain side: a loaded slot writes whenever its FIFO has room.
  assign out0_wr   = (r_st0 == ST_LOADED) & ~out0_full;
  assign out1_wr   = (r_st1 == ST_LOADED) & ~out1_full;
  assign out0_data = r_hold0;
  assign out1_data = r_hold1;

  // A slot draining this cycle can accept the next token in the same cycle.
  assign w_tag   = in_data[WIDTH-1];
  assign w_free0 = (r_st0 == ST_EMPTY) | out0_wr;
  assign w_free1 = (r_st1 == ST_EMPTY) | out1_wr;
  assign in_read = ~rst & ~in_empty & (w_tag ? w_free1 : w_free0);
  assign w_load0 = in_read & ~w_tag;
  assign w_load1 = in_read &  w_tag;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_st0   <= ST_EMPTY;
      r_hold0 <= '0;
    end else if (w_load0) begin
      r_st0   <= ST_LOADED;
      r_hold0 <= in_data[WIDTH-2:0];
    end else if (out0_wr) begin
      r_st0   <= ST_EMPTY;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_st1   <= ST_EMPTY;
      r_hold1 <= '0;
    end else if (w_load1) begin
      r_st1   <= ST_LOADED;
      r_hold1 <= in_data[WIDTH-2:0];
    end else if (out1_wr) begin
      r_st1   <= ST_EMPTY;
    end
  end

`ifdef DDF_SPLIT_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt0, r_cnt1;

  // Counters wrap naturally at the register width.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (out0_wr) r_cnt0 <= r_cnt0 + 1'b1;
      if (out1_wr) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

  assign out0_cnt = r_cnt0;
  assign out1_cnt = r_cnt1;
`endif

endmodule

`default_nettype wire

// File: doc/ddf_2f_tag_split.md
Name: ddf_2f_tag_split

Overview:
- Downstream stage of the 2-flow pick/accumulate actor.
- Consumes its tagged result tokens, {tag, acc[WIDTH-2:0]}, from a first-word-fall-through FIFO.
- Strips the tag bit and routes the payload to one of two output FIFOs (flow 0 / flow 1).
- One registered holding slot per output gives 1-cycle latency. One flow can drain while the other output is stalled.

Parameters:
- WIDTH, 8, input token width; bit WIDTH-1 is the tag, bits WIDTH-2:0 are the payload.
- CNT_WIDTH, 16, width of the per-flow token counters (only used with DDF_SPLIT_CNT_EN).

Ports:
- ck  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_data  input  WIDTH  head token of the upstream FIFO, valid while in_empty==0 (FWFT)
- in_empty  input  1  upstream FIFO empty
- in_read  output  1  pop upstream FIFO this cycle
- out0_full  input  1  flow-0 output FIFO full
- out0_wr  output  1  write flow-0 output FIFO
- out0_data  output  WIDTH-1  flow-0 payload
- out1_full  input  1  flow-1 output FIFO full
- out1_wr  output  1  write flow-1 output FIFO
- out1_data  output  WIDTH-1  flow-1 payload
- out0_cnt  output  CNT_WIDTH  flow-0 tokens written (DDF_SPLIT_CNT_EN only)
- out1_cnt  output  CNT_WIDTH  flow-1 tokens written (DDF_SPLIT_CNT_EN only)

Behaviour:
- State per flow x in {0,1}:
  - Holding register hold_x[WIDTH-2:0].
  - Valid bit v_x; state EMPTY (v_x=0) or LOADED (v_x=1).
- Reset (async, rst=1):
  - v0=v1=0, hold0=hold1=0.
  - in_read=0, out0_wr=out1_wr=0, out0_data=out1_data=0.
  - Counters 0.
  - Reset mid-transfer drops held tokens; no partial write is issued.
- Drain, combinational:
  - outx_wr = v_x & ~outx_full.
  - outx_data = hold_x at all times.
- Accept:
  - tag = in_data[WIDTH-1]; dest = tag.
  - slot_free_dest = ~v_dest | outx_wr (drain this cycle frees the slot).
  - in_read = ~in_empty & slot_free_dest.
  - in_read is never asserted while in_empty=1.
- Sequential update per flow x, at the clock edge:
  - Load (in_read & dest==x): hold_x <= in_data[WIDTH-2:0], v_x <= 1. Applies whether or not outx_wr is high in the same cycle, so back-to-back throughput is 1 token/cycle.
  - Drain without load (outx_wr & no load to x): v_x <= 0; hold_x keeps its value.
  - Neither: v_x and hold_x hold.
- Latency: token popped in cycle N is presented with outx_wr=1 in cycle N+1 if outx_full=0.
- Ordering:
  - Per-flow order is preserved.
  - Head-of-line: if the head token targets a LOADED slot whose output is full, in_read=0 and the other flow stalls behind it. This is accepted behaviour because the input is a single FIFO.
- Simultaneous events:
  - Both outputs may write in the same cycle.
  - Load and drain on the same flow in the same cycle: drain uses the old hold_x; the new token is captured.
- Full held indefinitely: v_x stays 1, data stable, outx_wr=0, no token lost or duplicated.
- Payload width is WIDTH-1 bits, passed unmodified; no arithmetic on data.

Optional Feature:
- Macro DDF_SPLIT_CNT_EN.
- Defined:
  - out0_cnt/out1_cnt ports exist.
  - Each increments by 1 on every cycle its outx_wr=1.
  - Wraps modulo 2^CNT_WIDTH (all-ones -> 0).
  - Reset to 0 by rst.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: apply rst with in_empty=0, in_data=8'h85 -> in_read=0, out0_wr=out1_wr=0 and both data outputs 0 while rst=1; after release, first in_read=1 next cycle.
- Single routing, WIDTH=8:
  - Push 8'h85 -> out1_wr=1 with out1_data=7'h05 exactly one cycle after the pop.
  - Push 8'h2A -> out0_data=7'h2A; the other port's wr stays 0.
- Streaming: 16 tokens alternating tags, both fulls low -> in_read high 16 consecutive cycles; 8 writes per port, in order, no gaps after the first.
- Backpressure:
  - Hold out0_full=1, push 0x01, 0x02, 0x83 -> 0x01 held in slot0, in_read=0 on 0x02, 0x83 not popped (head-of-line).
  - Release full -> 0x01, 0x02 out in order, then 0x03 on port 1; none lost or duplicated.
- Simultaneous: slot0 LOADED, out0_full drops in the same cycle a tag-0 token is at the head -> out0_wr=1 with the old value and in_read=1; the new value appears next cycle.
- Counters (DDF_SPLIT_CNT_EN, CNT_WIDTH=4): 17 tag-1 writes -> out1_cnt=1 (wrapped), out0_cnt=0; rst clears both.
